// File: rtl/lab_two_response_checker_if.sv
// Bus between the Lab Two response checker and its environment.
//   start            run request (level-sampled)
//   abcd             converter inputs {A,B,C,D}, A is MSB
//   klmn             converter outputs {K,L,M,N}, K is MSB
//   busy/done/pass   run status
//   err_count        mismatching codes this run
//   fail_valid       at least one mismatch recorded
//   first_fail_code  code of the first mismatch
//   first_fail_value klmn seen at the first mismatch
// master: stimulus/converter side. slave: the checker.
interface lab_two_response_checker_if;
  logic       start;
  logic [3:0] abcd;
  logic [3:0] klmn;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_count;
  logic       fail_valid;
  logic [3:0] first_fail_code;
  logic [3:0] first_fail_value;

  modport master (
    output start, klmn,
    input  abcd, busy, done, pass, err_count, fail_valid,
           first_fail_code, first_fail_value
  );

  modport slave (
    input  start, klmn,
    output abcd, busy, done, pass, err_count, fail_valid,
           first_fail_code, first_fail_value
  );
endinterface

// File: rtl/lab_two_response_checker.sv
// Stimulus/response checker for the Lab Two 4-in/4-out code converter.
// Steps abcd through codes 0..NUM_CODES-1, holds each for SETTLE_CYCLES
// cycles, samples klmn on the edge ending the following SAMPLE cycle and
// compares it with the nibble of EXPECTED for that code. Reports mismatch
// count and the first failing code/value.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    checker side of lab_two_response_checker_if (see that file)
module lab_two_response_checker #(
  parameter int          NUM_CODES     = 16,
  parameter int          SETTLE_CYCLES = 4,
  parameter logic [63:0] EXPECTED      = 64'h89BAEFDC45762310
) (
  input logic                       clk,
  input logic                       rst_n,
  lab_two_response_checker_if.slave bus
);

  localparam int            CW        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT  = CW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]    LAST_CODE = 4'(NUM_CODES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t        state, state_nxt;
  logic [3:0]    code;
  logic [CW-1:0] cnt;
  logic [4:0]    err_count;
  logic          busy, done, pass, fail_valid;
  logic [3:0]    ff_code, ff_value;

  logic          accept;
  logic          mismatch;
  logic          last;
  logic [3:0]    exp_nib;
  logic [4:0]    err_nxt;

  assign exp_nib  = EXPECTED[{code, 2'b00} +: 4];
  assign mismatch = (bus.klmn != exp_nib);
  assign last     = (code == LAST_CODE);
  // Count including the current sample, so pass reflects the final result.
  assign err_nxt  = err_count + {4'b0000, mismatch};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: if (bus.start) begin
        accept    = 1'b1;
        state_nxt = SETTLE;
      end
      SETTLE:  if (cnt == '0) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = last ? DONE : SETTLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code       <= '0;
      cnt        <= '0;
      err_count  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_valid <= 1'b0;
      ff_code    <= '0;
      ff_value   <= '0;
    end else if (accept) begin
      code       <= '0;
      cnt        <= CNT_INIT;
      err_count  <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_valid <= 1'b0;
      ff_code    <= '0;
      ff_value   <= '0;
    end else if (state == SETTLE) begin
      if (cnt != '0) cnt <= cnt - CW'(1);
    end else if (state == SAMPLE) begin
      err_count <= err_nxt;
      if (mismatch && !fail_valid) begin
        fail_valid <= 1'b1;
        ff_code    <= code;
        ff_value   <= bus.klmn;
      end
      if (last) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_nxt == 5'd0);
      end else begin
        code <= code + 4'd1;
        cnt  <= CNT_INIT;
      end
    end
  end

  // abcd comes straight from the code register: no decode glitches.
  assign bus.abcd             = code;
  assign bus.busy             = busy;
  assign bus.done             = done;
  assign bus.pass             = pass;
  assign bus.err_count        = err_count;
  assign bus.fail_valid       = fail_valid;
  assign bus.first_fail_code  = ff_code;
  assign bus.first_fail_value = ff_value;

endmodule

// File: tb/tb_lab_two_response_checker.sv
module tb_lab_two_response_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  lab_two_response_checker_if bus ();
  lab_two_response_checker_if bus2 ();

  lab_two_response_checker dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  lab_two_response_checker #(.NUM_CODES(8), .SETTLE_CYCLES(1)) dut_small (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  // Converter model: 0 = Gray, 1 = tied 0, 2 = Gray with code 9 -> C, 3 = identity
  int mode = 0;

  function automatic logic [3:0] gray(input logic [3:0] a);
    return a ^ (a >> 1);
  endfunction

  always_comb begin
    case (mode)
      1:       bus.klmn = 4'h0;
      2:       bus.klmn = (bus.abcd == 4'd9) ? 4'hC : gray(bus.abcd);
      3:       bus.klmn = bus.abcd;
      default: bus.klmn = gray(bus.abcd);
    endcase
  end
  assign bus2.klmn = gray(bus2.abcd);

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_abcd"}, 32'(bus.abcd), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_pass"}, 32'(bus.pass), 0);
    chk({tag, "_err"},  32'(bus.err_count), 0);
    chk({tag, "_fv"},   32'(bus.fail_valid), 0);
    chk({tag, "_ffc"},  32'(bus.first_fail_code), 0);
    chk({tag, "_ffv"},  32'(bus.first_fail_value), 0);
  endtask

  // Start a run on the main DUT and follow it until done (bounded).
  // done_cyc = edges after the accepting edge at which done is seen, -1 on timeout.
  task automatic run_main(input bit hold, output int done_cyc, output bit seq_ok);
    int j;
    seq_ok   = 1'b1;
    done_cyc = -1;
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
    j = 0;
    while (j <= 200) begin
      if (bus.done) begin
        done_cyc = j;
        break;
      end
      if (bus.abcd != 4'(j / 5) || !bus.busy) seq_ok = 1'b0;
      @(posedge clk); #1;
      j++;
    end
  endtask

  typedef struct {
    string      name;
    int         mode;
    logic [4:0] err;
    logic       fv;
    logic [3:0] ffc;
    logic [3:0] ffv;
    logic       pass;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int  dc;
    bit  ok;
    logic [4:0] e_hold;

    vecs[0] = '{"gray",     0, 5'd0,  1'b0, 4'h0, 4'h0, 1'b1};
    vecs[1] = '{"tie0",     1, 5'd15, 1'b1, 4'h1, 4'h0, 1'b0};
    vecs[2] = '{"fault9",   2, 5'd1,  1'b1, 4'h9, 4'hC, 1'b0};
    vecs[3] = '{"identity", 3, 5'd14, 1'b1, 4'h2, 4'h2, 1'b0};

    bus.start  = 1'b0;
    bus2.start = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven full runs with defaults
    foreach (vecs[i]) begin
      mode = vecs[i].mode;
      run_main(1'b0, dc, ok);
      chk({vecs[i].name, "_done_cycle"}, 32'(dc), 80);
      chk({vecs[i].name, "_abcd_seq"},   32'(ok), 1);
      chk({vecs[i].name, "_busy_low"},   32'(bus.busy), 0);
      chk({vecs[i].name, "_abcd_last"},  32'(bus.abcd), 15);
      chk({vecs[i].name, "_err"},        32'(bus.err_count), 32'(vecs[i].err));
      chk({vecs[i].name, "_fv"},         32'(bus.fail_valid), 32'(vecs[i].fv));
      chk({vecs[i].name, "_ffc"},        32'(bus.first_fail_code), 32'(vecs[i].ffc));
      chk({vecs[i].name, "_ffv"},        32'(bus.first_fail_value), 32'(vecs[i].ffv));
      chk({vecs[i].name, "_pass"},       32'(bus.pass), 32'(vecs[i].pass));
    end

    // Results hold in DONE while start stays low
    e_hold = bus.err_count;
    repeat (4) @(posedge clk);
    #1;
    chk("hold_done", 32'(bus.done), 1);
    chk("hold_err",  32'(bus.err_count), 32'(e_hold));
    chk("hold_abcd", 32'(bus.abcd), 15);

    // start held high: no mid-run restart, re-accepted one cycle after done
    mode = 1;
    run_main(1'b1, dc, ok);
    chk("held_done_cycle", 32'(dc), 80);
    chk("held_abcd_seq",   32'(ok), 1);
    chk("held_err",        32'(bus.err_count), 15);
    @(posedge clk); #1;
    chk("restart_done", 32'(bus.done), 0);
    chk("restart_busy", 32'(bus.busy), 1);
    chk("restart_err",  32'(bus.err_count), 0);
    chk("restart_abcd", 32'(bus.abcd), 0);
    chk("restart_fv",   32'(bus.fail_valid), 0);
    bus.start = 1'b0;

    // Mid-run async reset at cycle 30 (tie0 so there is state to clear)
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mode = 1;
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("pre_rst_err", 32'(bus.err_count), 5);
    @(negedge clk); #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_busy", 32'(bus.busy), 0);
    chk("post_rst_done", 32'(bus.done), 0);
    chk("post_rst_abcd", 32'(bus.abcd), 0);
    mode = 0;
    run_main(1'b0, dc, ok);
    chk("post_rst_done_cycle", 32'(dc), 80);
    chk("post_rst_seq",        32'(ok), 1);
    chk("post_rst_pass",       32'(bus.pass), 1);

    // Small instance: 8 codes, 1 settle cycle
    begin
      int  j;
      int  sdc;
      bit  sok;
      sok = 1'b1;
      sdc = -1;
      @(negedge clk); bus2.start = 1'b1;
      @(posedge clk); #1 bus2.start = 1'b0;
      j = 0;
      while (j <= 100) begin
        if (bus2.done) begin
          sdc = j;
          break;
        end
        if (bus2.abcd != 4'(j / 2) || !bus2.busy) sok = 1'b0;
        @(posedge clk); #1;
        j++;
      end
      chk("small_done_cycle", 32'(sdc), 16);
      chk("small_seq",        32'(sok), 1);
      chk("small_pass",       32'(bus2.pass), 1);
      chk("small_err",        32'(bus2.err_count), 0);
      chk("small_abcd_last",  32'(bus2.abcd), 7);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
